hazard_unit: RTL and testbench

HAZARD_UNIT -- requirements
Module: hazard_unit

---
 rtl/hazard_unit_pkg.sv | 37 +++
 rtl/sat_counter16.sv | 27 ++
 rtl/hazard_unit.sv | 130 +++++++++++++
 tb/tb_hazard_unit.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/hazard_unit_pkg.sv
// Shared pipeline definitions: register-index width, hazard FSM encoding,
// forwarding select codes and the load-use hazard predicate.
package hazard_unit_pkg;

    localparam int unsigned REG_IDX_W   = 3;
    localparam int unsigned STATE_W     = 2;
    localparam int unsigned CNT_W       = 16;
    localparam int unsigned FLUSH_CNT_W = 3;

    typedef logic [REG_IDX_W-1:0] reg_idx_t;

    // Hazard FSM state encoding
    localparam logic [STATE_W-1:0] ST_RUN     = 2'd0;
    localparam logic [STATE_W-1:0] ST_LDSTALL = 2'd1;
    localparam logic [STATE_W-1:0] ST_FLUSH   = 2'd2;

    // Forwarding mux select codes used by the EX operand muxes
    localparam logic [1:0] FWD_REG    = 2'b00;
    localparam logic [1:0] FWD_MEM_WB = 2'b01;
    localparam logic [1:0] FWD_EX_MEM = 2'b10;

    // A load in EX whose destination a used ID source matches; r0 never stalls
    function automatic logic load_use_hazard(
        input reg_idx_t r1,
        input reg_idx_t r2,
        input logic     use_r1,
        input logic     use_r2,
        input reg_idx_t dst,
        input logic     mem_read,
        input logic     reg_write
    );
        logic match;
        match = (use_r1 && (r1 == dst)) || (use_r2 && (r2 == dst));
        return mem_read && reg_write && (dst != reg_idx_t'(0)) && match;
    endfunction

endpackage

// File: rtl/sat_counter16.sv
// 16-bit event counter that sticks at all-ones instead of wrapping.
// Ports:
//   clk   - clock
//   clr   - synchronous active-low clear
//   inc   - count one event this cycle
//   count - registered count value
module sat_counter16
    import hazard_unit_pkg::*;
(
    input  logic             clk,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    // Clear wins; increments stop at CNT_MAX
    always_ff @(posedge clk) begin
        if (!clr) begin
            count <= '0;
        end else if (inc && (count != CNT_MAX)) begin
            count <= count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/hazard_unit.sv
// Pipeline hazard unit: load-use stall detection, taken-branch flushing of
// IF/ID and ID/EX for FLUSH_CYCLES cycles, and stall/flush event counters.
// Control outputs respond combinationally to the current cycle's inputs.
// Ports:
//   clk, rst              - clock, synchronous active-low reset
//   R1, R2, UseR1, UseR2  - ID source registers and their use flags
//   RegDst2, MemRead2,
//   RegWrite2             - EX destination, load flag, write-enable
//   BranchTaken           - EX branch resolved taken this cycle
//   PCWrite, IFIDWrite    - PC / IF/ID update enables
//   Bubble                - zero the control word entering ID/EX
//   IFIDFlush, IDEXFlush  - clear IF/ID / ID/EX
//   StallCount,FlushCount - saturating event counters
module hazard_unit
    import hazard_unit_pkg::*;
#(
    parameter int unsigned FLUSH_CYCLES = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [REG_IDX_W-1:0] R1,
    input  logic [REG_IDX_W-1:0] R2,
    input  logic                 UseR1,
    input  logic                 UseR2,
    input  logic [REG_IDX_W-1:0] RegDst2,
    input  logic                 MemRead2,
    input  logic                 RegWrite2,
    input  logic                 BranchTaken,
    output logic                 PCWrite,
    output logic                 IFIDWrite,
    output logic                 Bubble,
    output logic                 IFIDFlush,
    output logic                 IDEXFlush,
    output logic [CNT_W-1:0]     StallCount,
    output logic [CNT_W-1:0]     FlushCount
);

    localparam logic [FLUSH_CNT_W-1:0] FLUSH_RELOAD = FLUSH_CNT_W'(FLUSH_CYCLES - 1);

    logic [STATE_W-1:0]     state;
    logic [STATE_W-1:0]     next_state;
    logic [FLUSH_CNT_W-1:0] flush_cnt;
    logic [FLUSH_CNT_W-1:0] next_flush_cnt;
    logic                   hazard;
    logic                   stall_inc;
    logic                   flush_inc;

    assign hazard = load_use_hazard(R1, R2, UseR1, UseR2, RegDst2, MemRead2, RegWrite2);

    // State and flush down-counter
    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= ST_RUN;
            flush_cnt <= '0;
        end else begin
            state     <= next_state;
            flush_cnt <= next_flush_cnt;
        end
    end

    // Next-state and control outputs
    always_comb begin
        next_state     = ST_RUN;
        next_flush_cnt = '0;
        PCWrite        = 1'b1;
        IFIDWrite      = 1'b1;
        Bubble         = 1'b0;
        IFIDFlush      = 1'b0;
        IDEXFlush      = 1'b0;
        stall_inc      = 1'b0;
        flush_inc      = 1'b0;

        if (!rst) begin
            // Freeze front end and scrub both pipeline registers
            PCWrite   = 1'b0;
            IFIDWrite = 1'b0;
            Bubble    = 1'b1;
            IFIDFlush = 1'b1;
            IDEXFlush = 1'b1;
        end else begin
            case (state)
                ST_RUN, ST_LDSTALL: begin
                    if (BranchTaken) begin
                        // Branch beats any load-use stall this cycle
                        IFIDFlush = 1'b1;
                        IDEXFlush = 1'b1;
                        flush_inc = 1'b1;
                        if (FLUSH_CYCLES > 1) begin
                            next_state     = ST_FLUSH;
                            next_flush_cnt = FLUSH_RELOAD;
                        end
                    end else if ((state == ST_RUN) && hazard) begin
                        // EX holds a bubble in LDSTALL, so no re-detection there
                        PCWrite    = 1'b0;
                        IFIDWrite  = 1'b0;
                        Bubble     = 1'b1;
                        stall_inc  = 1'b1;
                        next_state = ST_LDSTALL;
                    end
                end
                ST_FLUSH: begin
                    IFIDFlush      = 1'b1;
                    IDEXFlush      = 1'b1;
                    next_flush_cnt = flush_cnt - FLUSH_CNT_W'(1);
                    if (next_flush_cnt != '0) begin
                        next_state = ST_FLUSH;
                    end
                end
                default: begin
                    next_state = ST_RUN;
                end
            endcase
        end
    end

    sat_counter16 u_stall_cnt (
        .clk   (clk),
        .clr   (rst),
        .inc   (stall_inc),
        .count (StallCount)
    );

    sat_counter16 u_flush_cnt (
        .clk   (clk),
        .clr   (rst),
        .inc   (flush_inc),
        .count (FlushCount)
    );

endmodule

// File: tb/tb_hazard_unit.sv
// Bench for hazard_unit: FLUSH_CYCLES=1 and FLUSH_CYCLES=3 instances share
// stimulus; a standalone sat_counter16 exercises counter saturation.
module tb_hazard_unit;

    logic        clk;
    logic        rst;
    logic [2:0]  R1, R2, RegDst2;
    logic        UseR1, UseR2, MemRead2, RegWrite2, BranchTaken;

    logic        a_pcw, a_ifw, a_bub, a_iff, a_ief;
    logic [15:0] a_sc, a_fc;
    logic        b_pcw, b_ifw, b_bub, b_iff, b_ief;
    logic [15:0] b_sc, b_fc;

    logic        sc_clr, sc_inc;
    logic [15:0] sc_count;

    typedef struct {
        logic [4:0]  ctl;      // {PCWrite, IFIDWrite, Bubble, IFIDFlush, IDEXFlush}
        logic [15:0] stalls;
        logic [15:0] flushes;
    } exp_t;

    exp_t sb_a[$];
    exp_t sb_b[$];

    int n_cmp;
    int n_bad;

    // Reference model state, index 0: FLUSH_CYCLES=1, index 1: FLUSH_CYCLES=3
    bit m_ldstall[2];
    int m_left[2];
    int m_sc[2];
    int m_fc[2];

    hazard_unit #(.FLUSH_CYCLES(1)) dut_a (
        .clk(clk), .rst(rst), .R1(R1), .R2(R2), .UseR1(UseR1), .UseR2(UseR2),
        .RegDst2(RegDst2), .MemRead2(MemRead2), .RegWrite2(RegWrite2),
        .BranchTaken(BranchTaken), .PCWrite(a_pcw), .IFIDWrite(a_ifw),
        .Bubble(a_bub), .IFIDFlush(a_iff), .IDEXFlush(a_ief),
        .StallCount(a_sc), .FlushCount(a_fc)
    );

    hazard_unit #(.FLUSH_CYCLES(3)) dut_b (
        .clk(clk), .rst(rst), .R1(R1), .R2(R2), .UseR1(UseR1), .UseR2(UseR2),
        .RegDst2(RegDst2), .MemRead2(MemRead2), .RegWrite2(RegWrite2),
        .BranchTaken(BranchTaken), .PCWrite(b_pcw), .IFIDWrite(b_ifw),
        .Bubble(b_bub), .IFIDFlush(b_iff), .IDEXFlush(b_ief),
        .StallCount(b_sc), .FlushCount(b_fc)
    );

    sat_counter16 u_sat (
        .clk(clk), .clr(sc_clr), .inc(sc_inc), .count(sc_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Expected outputs for this cycle, then advance the model across the edge
    task automatic model_step(input int i, output exp_t e);
        int  fcyc;
        bit  haz;
        fcyc = (i == 0) ? 1 : 3;
        haz  = MemRead2 && RegWrite2 && (RegDst2 != 3'd0) &&
               ((UseR1 && (R1 == RegDst2)) || (UseR2 && (R2 == RegDst2)));
        e.stalls  = 16'(m_sc[i]);
        e.flushes = 16'(m_fc[i]);
        if (!rst) begin
            e.ctl = 5'b00111;
            m_ldstall[i] = 1'b0; m_left[i] = 0; m_sc[i] = 0; m_fc[i] = 0;
        end else if (m_left[i] > 0) begin
            e.ctl = 5'b11011;
            m_left[i]--;
            m_ldstall[i] = 1'b0;
        end else if (BranchTaken) begin
            e.ctl = 5'b11011;
            if (m_fc[i] < 65535) m_fc[i]++;
            m_left[i] = fcyc - 1;
            m_ldstall[i] = 1'b0;
        end else if (!m_ldstall[i] && haz) begin
            e.ctl = 5'b00100;
            if (m_sc[i] < 65535) m_sc[i]++;
            m_ldstall[i] = 1'b1;
        end else begin
            e.ctl = 5'b11000;
            m_ldstall[i] = 1'b0;
        end
    endtask

    task automatic compare(input string tag);
        exp_t e;
        if (sb_a.size() > 0) begin
            e = sb_a.pop_front();
            check({tag, "/a ctl"},   32'({a_pcw, a_ifw, a_bub, a_iff, a_ief}), 32'(e.ctl));
            check({tag, "/a stall"}, 32'(a_sc), 32'(e.stalls));
            check({tag, "/a flush"}, 32'(a_fc), 32'(e.flushes));
        end
        if (sb_b.size() > 0) begin
            e = sb_b.pop_front();
            check({tag, "/b ctl"},   32'({b_pcw, b_ifw, b_bub, b_iff, b_ief}), 32'(e.ctl));
            check({tag, "/b stall"}, 32'(b_sc), 32'(e.stalls));
            check({tag, "/b flush"}, 32'(b_fc), 32'(e.flushes));
        end
    endtask

    // Drive one cycle at the falling edge, sample 2 time units later
    task automatic step(input logic r, input logic [2:0] r1, input logic [2:0] r2,
                        input logic u1, input logic u2, input logic [2:0] rd,
                        input logic mr, input logic rw, input logic bt, input string tag);
        exp_t e;
        rst = r; R1 = r1; R2 = r2; UseR1 = u1; UseR2 = u2;
        RegDst2 = rd; MemRead2 = mr; RegWrite2 = rw; BranchTaken = bt;
        model_step(0, e);
        sb_a.push_back(e);
        model_step(1, e);
        sb_b.push_back(e);
        #2;
        compare(tag);
        @(negedge clk);
    endtask

    task automatic idle(input string tag);
        step(1'b1, 3'd0, 3'd0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, tag);
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        rst = 1'b0; R1 = '0; R2 = '0; UseR1 = 1'b0; UseR2 = 1'b0;
        RegDst2 = '0; MemRead2 = 1'b0; RegWrite2 = 1'b0; BranchTaken = 1'b0;
        sc_clr = 1'b0; sc_inc = 1'b0;
        for (int i = 0; i < 2; i++) begin
            m_ldstall[i] = 1'b0; m_left[i] = 0; m_sc[i] = 0; m_fc[i] = 0;
        end
        repeat (2) @(negedge clk);

        // Held reset outputs, then clean RUN state
        step(1'b0, 3'd3, 3'd0, 1'b1, 1'b0, 3'd3, 1'b1, 1'b1, 1'b1, "in_reset");
        idle("after_reset");

        // Load-use on R1, then the stall cycle ignores the still-present hazard
        step(1'b1, 3'd3, 3'd0, 1'b1, 1'b0, 3'd3, 1'b1, 1'b1, 1'b0, "lu_r1");
        step(1'b1, 3'd3, 3'd0, 1'b1, 1'b0, 3'd3, 1'b1, 1'b1, 1'b0, "lu_r1_hold");
        idle("lu_r1_done");

        // Non-hazards: r0 destination, not a load, unused source, no write
        step(1'b1, 3'd0, 3'd0, 1'b1, 1'b0, 3'd0, 1'b1, 1'b1, 1'b0, "r0_dst");
        step(1'b1, 3'd3, 3'd0, 1'b1, 1'b0, 3'd3, 1'b0, 1'b1, 1'b0, "no_load");
        step(1'b1, 3'd3, 3'd0, 1'b0, 1'b0, 3'd3, 1'b1, 1'b1, 1'b0, "unused_src");
        step(1'b1, 3'd3, 3'd0, 1'b1, 1'b0, 3'd3, 1'b1, 1'b0, 1'b0, "no_write");

        // Load-use on R2
        step(1'b1, 3'd1, 3'd5, 1'b1, 1'b1, 3'd5, 1'b1, 1'b1, 1'b0, "lu_r2");
        idle("lu_r2_done");

        // Hazard and branch together: branch wins
        step(1'b1, 3'd4, 3'd0, 1'b1, 1'b0, 3'd4, 1'b1, 1'b1, 1'b1, "lu_plus_br");
        // Branches during the long flush are ignored by the 3-cycle instance
        step(1'b1, 3'd4, 3'd0, 1'b1, 1'b0, 3'd4, 1'b1, 1'b1, 1'b1, "flush_c2");
        step(1'b1, 3'd4, 3'd0, 1'b1, 1'b0, 3'd4, 1'b1, 1'b1, 1'b1, "flush_c3");
        idle("flush_end");
        idle("flush_quiet");

        // Branch during the stall cycle
        step(1'b1, 3'd2, 3'd0, 1'b1, 1'b0, 3'd2, 1'b1, 1'b1, 1'b0, "stall_then_br");
        step(1'b1, 3'd2, 3'd0, 1'b1, 1'b0, 3'd2, 1'b1, 1'b1, 1'b1, "br_in_ldstall");
        idle("br_ld_c2");
        idle("br_ld_c3");
        idle("br_ld_done");

        // Reset in the middle of a long flush
        step(1'b1, 3'd0, 3'd0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b1, "br_pre_rst");
        step(1'b0, 3'd0, 3'd0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, "rst_mid_flush");
        idle("post_rst1");
        idle("post_rst2");

        // Random traffic with a small register range to provoke hazards
        for (int k = 0; k < 400; k++) begin
            step(($urandom_range(63) != 0), 3'($urandom_range(3)), 3'($urandom_range(3)),
                 1'($urandom_range(1)), 1'($urandom_range(1)), 3'($urandom_range(3)),
                 1'($urandom_range(1)), ($urandom_range(3) != 0), ($urandom_range(7) == 0),
                 "rand");
        end

        // Back-to-back forced stalls
        for (int k = 0; k < 200; k++) begin
            step(1'b1, 3'd6, 3'd0, 1'b1, 1'b0, 3'd6, 1'b1, 1'b1, 1'b0, "forced");
        end

        // Counter saturation on the standalone instance
        sc_clr = 1'b1;
        sc_inc = 1'b1;
        repeat (65534) @(negedge clk);
        check("sat_65534", 32'(sc_count), 32'h0000_FFFE);
        @(negedge clk);
        check("sat_65535", 32'(sc_count), 32'h0000_FFFF);
        repeat (2) @(negedge clk);
        check("sat_65537", 32'(sc_count), 32'h0000_FFFF);
        sc_inc = 1'b0;
        sc_clr = 1'b0;
        @(negedge clk);
        check("sat_clear", 32'(sc_count), 32'h0000_0000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
